// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared datapath widths and constants for the pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;
    localparam int          REG_W    = 32;
    localparam int          RNUM_W   = 5;
    localparam logic [4:0]  ZERO_REG = 5'd0;
endpackage

`default_nettype wire

// File: rtl/regfile32.sv
// ============================================================================
// Module      : regfile32
// Description : 31 x 32-bit register file, r0 hardwired to zero, two async
//               read ports and one synchronous write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile32
    import pipe_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [RNUM_W-1:0] wa,
    input  logic [REG_W-1:0]  wd,
    input  logic [RNUM_W-1:0] ra,
    input  logic [RNUM_W-1:0] rb,
    output logic [REG_W-1:0]  qa,
    output logic [REG_W-1:0]  qb
);

    logic [REG_W-1:0] regs [1:31];

    // r0 has no storage; writes to it are dropped here as well as upstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != ZERO_REG)) begin
            regs[wa] <= wd;
        end
    end

    assign qa = (ra == ZERO_REG) ? '0 : regs[ra];
    assign qb = (rb == ZERO_REG) ? '0 : regs[rb];

endmodule

`default_nettype wire

// File: rtl/pipe_wb_regfile.sv
// ============================================================================
// Module      : pipe_wb_regfile
// Description : Writeback stage: wdi select, register file commit and write
//               counter. Define PIPE_WB_BYPASS_EN for same-cycle read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_wb_regfile
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wwreg,
    input  logic              wm2reg,
    input  logic [REG_W-1:0]  wmo,
    input  logic [REG_W-1:0]  walu,
    input  logic [RNUM_W-1:0] wrn,
    input  logic [RNUM_W-1:0] rna,
    input  logic [RNUM_W-1:0] rnb,
    output logic [REG_W-1:0]  qa,
    output logic [REG_W-1:0]  qb,
    output logic [REG_W-1:0]  wdi,
    output logic [CNT_W-1:0]  wbcnt
);

    logic             commit;
    logic [REG_W-1:0] rf_qa;
    logic [REG_W-1:0] rf_qb;

    assign wdi    = wm2reg ? wmo : walu;
    assign commit = wwreg && (wrn != ZERO_REG);

    regfile32 u_regfile (
        .clock (clock),
        .reset (reset),
        .we    (commit),
        .wa    (wrn),
        .wd    (wdi),
        .ra    (rna),
        .rb    (rnb),
        .qa    (rf_qa),
        .qb    (rf_qb)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbcnt <= '0;
        end else if (commit) begin
            wbcnt <= wbcnt + CNT_W'(1);
        end
    end

`ifdef PIPE_WB_BYPASS_EN
    // Forward the in-flight writeback value to a reader of the same register.
    assign qa = (commit && !reset && (wrn == rna)) ? wdi : rf_qa;
    assign qb = (commit && !reset && (wrn == rnb)) ? wdi : rf_qb;
`else
    assign qa = rf_qa;
    assign qb = rf_qb;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_wb_regfile.md
PIPE_WB_REGFILE -- requirements
Module: pipe_wb_regfile

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the committed-write counter.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port wwreg, input, 1: writeback register-write enable from MEM/WB register.
REQ-005 SHALL have port wm2reg, input, 1: select memory data (1) or ALU result (0) for writeback.
REQ-006 SHALL have port wmo, input, 32: memory data from MEM/WB register.
REQ-007 SHALL have port walu, input, 32: ALU result from MEM/WB register.
REQ-008 SHALL have port wrn, input, 5: destination register number.
REQ-009 SHALL have ports rna, rnb, input, 5 each: ID-stage read addresses.
REQ-010 SHALL have ports qa, qb, output, 32 each: ID-stage read data.
REQ-011 SHALL have port wdi, output, 32: selected writeback data, exported for EX/ID forwarding.
REQ-012 SHALL have port wbcnt, output, CNT_W: count of committed register writes.

Function
REQ-013 SHALL drive wdi combinationally: wm2reg=1 -> wmo; wm2reg=0 -> walu.
REQ-014 SHALL hold 31 32-bit registers r1..r31; r0 reads 0 always and is never written.
REQ-015 SHALL commit wdi into r[wrn] on a rising clock edge when wwreg=1, wrn!=0 and reset=0.
REQ-016 SHALL ignore writes with wrn=0 (no state change, counter not incremented).
REQ-017 SHALL drive qa/qb combinationally from r[rna]/r[rnb]; address 0 returns 32'h0.
REQ-018 SHALL increment wbcnt by 1 per committed write (REQ-015); wbcnt wraps from 2^CNT_W-1 to 0.
REQ-019 SHALL allow rna=rnb (both ports return the same value) and wrn equal to either read address (resolved per REQ-024/025).
REQ-020 SHALL have zero-cycle read latency and one-cycle write latency (value visible after the committing edge).

Reset
REQ-021 SHALL, on reset=1, immediately clear r1..r31 and wbcnt to 0, regardless of clock.
REQ-022 SHALL suppress all writes and counter updates while reset=1; qa/qb read 0 during reset.
REQ-023 SHALL resume normal writes on the first rising edge after reset deasserts; a write presented in the edge coincident with reset assertion is lost.

Configuration
REQ-024 SHALL, with macro PIPE_WB_BYPASS_EN defined, return wdi on qa (qb) when wwreg=1, wrn!=0, reset=0 and wrn=rna (wrn=rnb): same-cycle write-to-read bypass.
REQ-025 SHALL, with PIPE_WB_BYPASS_EN undefined, return the stored (pre-write) register value in that case; external forwarding covers the hazard.

Structure
REQ-026 SHALL take REG_W=32, RNUM_W=5 and ZERO_REG=5'd0 from shared package pipe_pkg.
REQ-027 SHALL instantiate one sub-module regfile32 (storage, r0 rule, two async read ports, one write port); bypass mux, wdi mux and counter stay in the top level.

Verification
REQ-028 Reset, then wwreg=1, wm2reg=0, walu=32'hDEADBEEF, wrn=5 for one edge; rna=5 -> qa=32'hDEADBEEF, wbcnt=1.
REQ-029 wwreg=1, wm2reg=1, wmo=32'h12345678, walu=32'hFFFFFFFF, wrn=0; rna=0 -> qa=0, wdi=32'h12345678, wbcnt unchanged.
REQ-030 r7=32'h1 stored; present wwreg=1, wdi=32'h2, wrn=7, rna=rnb=7 before edge -> qa=qb=32'h2 with PIPE_WB_BYPASS_EN, 32'h1 without; both 32'h2 after edge.
REQ-031 Write r3=32'hA5A5A5A5, assert reset mid-cycle (between edges) -> qa (rna=3)=0 and wbcnt=0 immediately; write held during reset not committed.
REQ-032 CNT_W=4: 16 committed writes to r1..r15 plus r1 -> wbcnt sequence 1..15 then 0; interleaved wwreg=0 cycles leave wbcnt unchanged.
